param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/param_register_file.sv | 141 ++++++++++++++
 tb/tb_param_register_file.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Parameterised two-read/one-write register file that zeroes itself with a
// clear sequence after reset. Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2,
    input  logic                  Read_En,
    input  logic [ADDR_WIDTH-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Sig_Reg_Write,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2,
    output logic                  Read_Valid,
    output logic                  Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r, clr_cnt_s;
    logic                    busy_s;
    logic                    usr_we_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic                    rd_fire_s;
    logic [DATA_WIDTH-1:0]   rd1_s, rd2_s;
    logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

    // Next-state, clear counter and write-port steering.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        busy_s      = 1'b1;
        usr_we_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_cnt_r;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        rd_fire_s   = 1'b0;
        case (state_r)
            CLEAR: begin
                mem_we_s = 1'b1;
                if (clr_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                    state_s   = READY;
                    clr_cnt_s = {ADDR_WIDTH{1'b0}};
                    busy_s    = 1'b0;
                end else begin
                    clr_cnt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                busy_s    = 1'b0;
                rd_fire_s = Read_En;
                // Entry 0 is never written when it is the hardwired zero register.
                if (ZERO_REG && (Write_Register == {ADDR_WIDTH{1'b0}})) begin
                    usr_we_s = 1'b0;
                end else begin
                    usr_we_s = Sig_Reg_Write;
                end
                mem_we_s    = usr_we_s;
                mem_waddr_s = Write_Register;
                mem_wdata_s = Write_Data;
            end
            default: begin
                state_s   = CLEAR;
                clr_cnt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Read-port data selection including zero register and optional forwarding.
    always_comb begin
        rd1_s = mem_r[Read_Register_1];
        rd2_s = mem_r[Read_Register_2];
`ifdef REGFILE_BYPASS_EN
        if (usr_we_s && (Read_Register_1 == Write_Register)) begin
            rd1_s = Write_Data;
        end else begin
            rd1_s = mem_r[Read_Register_1];
        end
        if (usr_we_s && (Read_Register_2 == Write_Register)) begin
            rd2_s = Write_Data;
        end else begin
            rd2_s = mem_r[Read_Register_2];
        end
`endif
        if (ZERO_REG && (Read_Register_1 == {ADDR_WIDTH{1'b0}})) begin
            rd1_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd1_s = rd1_s;
        end
        if (ZERO_REG && (Read_Register_2 == {ADDR_WIDTH{1'b0}})) begin
            rd2_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd2_s = rd2_s;
        end
    end

    // FSM state, clear counter and Busy flag registers.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_r   <= CLEAR;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
            Busy      <= 1'b1;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            Busy      <= busy_s;
        end
    end

    // Registered read outputs; data holds when no read fires.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            Read_Data_1 <= {DATA_WIDTH{1'b0}};
            Read_Data_2 <= {DATA_WIDTH{1'b0}};
            Read_Valid  <= 1'b0;
        end else begin
            Read_Valid <= rd_fire_s;
            if (rd_fire_s) begin
                Read_Data_1 <= rd1_s;
                Read_Data_2 <= rd2_s;
            end
        end
    end

    // Storage array; contents are zeroed by the clear sequence, not by reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed, table-driven bench for param_register_file (default and 8x16 builds).
module tb_param_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic        re, we;
    logic [31:0] wd, rd1, rd2;
    logic        rvalid, busy;

    logic        s_rst_n;
    logic [2:0]  s_ra1, s_ra2, s_wa;
    logic        s_re, s_we;
    logic [15:0] s_wd, s_rd1, s_rd2;
    logic        s_rvalid, s_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    param_register_file dut (
        .Clk(Clk), .Rst_N(rst_n),
        .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_En(re),
        .Write_Register(wa), .Write_Data(wd), .Sig_Reg_Write(we),
        .Read_Data_1(rd1), .Read_Data_2(rd2), .Read_Valid(rvalid), .Busy(busy)
    );

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) dut_s (
        .Clk(Clk), .Rst_N(s_rst_n),
        .Read_Register_1(s_ra1), .Read_Register_2(s_ra2), .Read_En(s_re),
        .Write_Register(s_wa), .Write_Data(s_wd), .Sig_Reg_Write(s_we),
        .Read_Data_1(s_rd1), .Read_Data_2(s_rd2), .Read_Valid(s_rvalid), .Busy(s_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        ev;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts edges until Busy drops on the default DUT, with requests held active.
    task automatic count_busy(output int cyc, output bit saw_valid);
        cyc = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (rvalid) saw_valid = 1'b1;
            if (!busy) break;
        end
        @(negedge Clk);
    endtask

    task automatic set_vec(input int i, input logic w, input logic [4:0] a, input logic [31:0] d,
                           input logic r, input logic [4:0] r1, input logic [4:0] r2,
                           input logic ev, input logic [31:0] e1, input logic [31:0] e2);
        vecs[i].we = w;  vecs[i].wa = a;   vecs[i].wd = d;
        vecs[i].re = r;  vecs[i].ra1 = r1; vecs[i].ra2 = r2;
        vecs[i].ev = ev; vecs[i].e1 = e1;  vecs[i].e2 = e2;
    endtask

    initial begin
        int  cyc;
        bit  saw_v;
        logic [31:0] byp_a5, byp_11;
        byp_a5 = BYP ? 32'hA5A5_A5A5 : 32'h0000_0000;
        byp_11 = BYP ? 32'h0000_0011 : 32'h0000_0000;

        set_vec(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        set_vec(1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        set_vec(2, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        set_vec(3, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd5, 1'b1, 32'h0, 32'hDEAD_BEEF);
        set_vec(4, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd7, 1'b1, byp_a5, byp_a5);
        set_vec(5, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd9, 1'b1, 32'hA5A5_A5A5, 32'h0);
        set_vec(6, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
        set_vec(7, 1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3, 5'd5, 1'b1, byp_11, 32'hDEAD_BEEF);
        set_vec(8, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 1'b1, 32'h11, 32'h11);
        set_vec(9, 1'b0, 5'd0, 32'h0,         1'b0, 5'd1, 5'd2, 1'b0, 32'h11, 32'h11);

        rst_n = 1'b0; s_rst_n = 1'b0;
        ra1 = 5'd0; ra2 = 5'd0; wa = 5'd0; wd = 32'h0; re = 1'b0; we = 1'b0;
        s_ra1 = 3'd0; s_ra2 = 3'd0; s_wa = 3'd0; s_wd = 16'h0; s_re = 1'b0; s_we = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_valid", {63'd0, rvalid}, 64'd0);
        check("rst_rd1", {32'd0, rd1}, 64'd0);
        check("rst_rd2", {32'd0, rd2}, 64'd0);

        // Release with requests held active: they must be ignored while clearing.
        we = 1'b1; wa = 5'd9; wd = 32'hFFFF_FFFF; re = 1'b1; ra1 = 5'd9; ra2 = 5'd9;
        rst_n = 1'b1;
        count_busy(cyc, saw_v);
        check("clear_cycles", 64'(cyc), 64'd32);
        check("clear_no_valid", {63'd0, saw_v}, 64'd0);
        we = 1'b0;

        // Back-to-back reads of every entry: all zero, Read_Valid every cycle.
        for (int i = 0; i < 32; i++) begin
            re = 1'b1; ra1 = 5'(i); ra2 = 5'(31 - i);
            @(posedge Clk); @(negedge Clk);
            check($sformatf("clr_valid[%0d]", i), {63'd0, rvalid}, 64'd1);
            check($sformatf("clr_rd1[%0d]", i), {32'd0, rd1}, 64'd0);
            check($sformatf("clr_rd2[%0d]", i), {32'd0, rd2}, 64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            re = vecs[i].re; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            @(posedge Clk); @(negedge Clk);
            check($sformatf("vec%0d_valid", i), {63'd0, rvalid}, {63'd0, vecs[i].ev});
            check($sformatf("vec%0d_rd1", i), {32'd0, rd1}, {32'd0, vecs[i].e1});
            check($sformatf("vec%0d_rd2", i), {32'd0, rd2}, {32'd0, vecs[i].e2});
        end
        we = 1'b0; re = 1'b0;

        // Reset during clear cycle 10 with writes active, then full clear again.
        rst_n = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        we = 1'b1; wa = 5'd12; wd = 32'hCAFE_F00D;
        repeat (10) @(posedge Clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd1);
        @(negedge Clk);
        rst_n = 1'b1;
        count_busy(cyc, saw_v);
        check("midrst_cycles", 64'(cyc), 64'd32);
        check("midrst_no_valid", {63'd0, saw_v}, 64'd0);
        check("midrst_rd1", {32'd0, rd1}, 64'd0);
        check("midrst_rd2", {32'd0, rd2}, 64'd0);
        we = 1'b0; re = 1'b1; ra1 = 5'd12; ra2 = 5'd5;
        @(posedge Clk); @(negedge Clk);
        check("midrst_rd12", {32'd0, rd1}, 64'd0);
        check("midrst_rd5", {32'd0, rd2}, 64'd0);
        check("midrst_rvalid", {63'd0, rvalid}, 64'd1);
        re = 1'b0;

        // Narrow instance: 8-entry clear, then write/read.
        @(negedge Clk);
        s_rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (!s_busy) break;
        end
        @(negedge Clk);
        check("s_clear_cycles", 64'(cyc), 64'd8);
        s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF;
        @(posedge Clk); @(negedge Clk);
        s_we = 1'b0; s_re = 1'b1; s_ra1 = 3'd7; s_ra2 = 3'd1;
        @(posedge Clk); @(negedge Clk);
        check("s_rd1", {48'd0, s_rd1}, 64'h0000_0000_0000_BEEF);
        check("s_rd2", {48'd0, s_rd2}, 64'd0);
        check("s_valid", {63'd0, s_rvalid}, 64'd1);
        s_re = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("s_valid_drop", {63'd0, s_rvalid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
